// File: rtl/mips32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mips32_mem_arbiter
// Brief    : Shares one single-port synchronous word memory between the
//            instruction-fetch port and the MEM-stage data port. Data has
//            fixed priority, a streak guard bounds fetch starvation, and the
//            HALTED flag drains outstanding reads before freezing the port.
//            Define MEM_ARB_STATS_EN to add saturating grant/conflict counters.
// Revision : 1.0 - initial release
// ============================================================================
module mips32_mem_arbiter #(
    parameter int AW          = 10,
    parameter int DW          = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          halted,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    arb_state
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_if_grants,
    output logic [15:0]   stat_d_grants,
    output logic [15:0]   stat_conflicts
`endif
);

    localparam logic [1:0] c_RUN   = 2'd0;
    localparam logic [1:0] c_DRAIN = 2'd1;
    localparam logic [1:0] c_HALT  = 2'd2;
    localparam logic [3:0] c_MAX   = 4'(MAX_DSTREAK);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [3:0]    r_streak;
    logic          w_force_if;
    logic          w_if_gnt;
    logic          w_d_gnt;
    logic          w_rd_issue;
    logic          r_pend_v;
    logic          r_pend_d;
    logic          r_if_rvalid;
    logic          r_d_rvalid;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_state <= c_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_RUN:   if (halted) w_state_nxt = c_DRAIN;
            // A read granted in the last RUN cycle returns on the way into DRAIN
            c_DRAIN: if (!r_pend_v) w_state_nxt = c_HALT;
            c_HALT:  w_state_nxt = c_HALT;
            default: w_state_nxt = c_HALT;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (grants)
    // ------------------------------------------------------------------
    assign w_force_if = if_req && (r_streak == c_MAX);

    always_comb begin
        w_if_gnt = 1'b0;
        w_d_gnt  = 1'b0;
        if (!rst && (r_state == c_RUN) && !halted) begin
            if (d_req && !w_force_if) begin
                w_d_gnt = 1'b1;
            end else if (if_req) begin
                w_if_gnt = 1'b1;
            end
        end
    end

    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign arb_state = r_state;

    // ------------------------------------------------------------------
    // Memory port mux
    // ------------------------------------------------------------------
    assign mem_en    = w_if_gnt | w_d_gnt;
    assign mem_we    = w_d_gnt & d_we;
    assign mem_addr  = w_d_gnt ? d_addr : (w_if_gnt ? if_addr : '0);
    assign mem_wdata = w_d_gnt ? d_wdata : '0;

    // ------------------------------------------------------------------
    // Data-grant streak while a fetch is waiting
    // ------------------------------------------------------------------
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_streak <= 4'd0;
        end else if (w_if_gnt || !if_req) begin
            r_streak <= 4'd0;
        end else if (w_d_gnt && (r_streak != c_MAX)) begin
            r_streak <= r_streak + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Read return: owner tag, then registered valid/data one cycle later
    // ------------------------------------------------------------------
    assign w_rd_issue = w_if_gnt | (w_d_gnt & !d_we);

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_pend_v <= 1'b0;
            r_pend_d <= 1'b0;
        end else begin
            r_pend_v <= w_rd_issue;
            r_pend_d <= w_d_gnt;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_if_rvalid <= r_pend_v & !r_pend_d;
            r_d_rvalid  <= r_pend_v & r_pend_d;
            if (r_pend_v && !r_pend_d) begin
                r_if_rdata <= mem_rdata;
            end
            if (r_pend_v && r_pend_d) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;

`ifdef MEM_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics counters
    // ------------------------------------------------------------------
    logic [15:0] r_stat_if;
    logic [15:0] r_stat_d;
    logic [15:0] r_stat_cf;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_stat_if <= 16'd0;
            r_stat_d  <= 16'd0;
            r_stat_cf <= 16'd0;
        end else begin
            if (w_if_gnt && (r_stat_if != 16'hFFFF)) r_stat_if <= r_stat_if + 16'd1;
            if (w_d_gnt && (r_stat_d != 16'hFFFF))   r_stat_d  <= r_stat_d + 16'd1;
            if (if_req && d_req && (r_stat_cf != 16'hFFFF)) r_stat_cf <= r_stat_cf + 16'd1;
        end
    end

    assign stat_if_grants = r_stat_if;
    assign stat_d_grants  = r_stat_d;
    assign stat_conflicts = r_stat_cf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips32_mem_arbiter
// Brief    : Scoreboard bench for mips32_mem_arbiter with a behavioural
//            single-port synchronous memory; directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips32_mem_arbiter;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        halted;
    logic        if_req;
    logic [9:0]  if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic [1:0]  arb_state;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] stat_if_grants;
    logic [15:0] stat_d_grants;
    logic [15:0] stat_conflicts;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_if[$];
    logic [31:0] exp_d[$];
    logic [1:0]  exp_gnt[$];

    logic        preload;
    logic [31:0] tb_mem [0:1023];

    always #5 clk1 = ~clk1;

    mips32_mem_arbiter #(.AW(10), .DW(32), .MAX_DSTREAK(4)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .halted    (halted),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .arb_state (arb_state)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_if_grants (stat_if_grants),
        .stat_d_grants  (stat_d_grants),
        .stat_conflicts (stat_conflicts)
`endif
    );

    // Behavioural single-port synchronous memory
    always @(posedge clk1) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= 32'(i) * 32'd7;
            for (int i = 0; i < 8; i++) tb_mem[i] <= 32'h28010078 + 32'(i);
            tb_mem[120] <= 32'd85;
        end else if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clk1);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a response
    always @(negedge clk1) begin
        if (exp_gnt.size() != 0) begin
            logic [1:0] g;
            g = exp_gnt.pop_front();
            check("grant", 32'({d_gnt, if_gnt}), 32'(g));
        end
        if (if_gnt && d_gnt) check("both_grants", 32'd1, 32'd0);
        if (if_rvalid) begin
            if (exp_if.size() == 0) check("if_rvalid_unexpected", 32'd1, 32'd0);
            else check("if_rdata", if_rdata, exp_if.pop_front());
        end
        if (d_rvalid) begin
            if (exp_d.size() == 0) check("d_rvalid_unexpected", 32'd1, 32'd0);
            else check("d_rdata", d_rdata, exp_d.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] pat;
        rst = 1'b1; halted = 1'b0; preload = 1'b1;
        if_req = 1'b1; if_addr = 10'd0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'd0; d_wdata = 32'hDEADBEEF;
        next();
        // Reset state, with requests asserted to prove gating
        check("rst_if_gnt", 32'(if_gnt), 32'd0);
        check("rst_d_gnt", 32'(d_gnt), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_state", 32'(arb_state), 32'd0);
        preload = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = 32'd0;
        next();
        rst = 1'b0;
        next();

        // Fetch-only stream
        for (int a = 0; a < 8; a++) begin
            if_req = 1'b1; if_addr = 10'(a);
            exp_gnt.push_back(2'b01);
            exp_if.push_back(32'h28010078 + 32'(a));
            next();
        end
        if_req = 1'b0;
        repeat (3) next();

        // Load / store / load-back
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd120;
        exp_gnt.push_back(2'b10); exp_d.push_back(32'd85);
        next();
        d_we = 1'b1; d_addr = 10'd121; d_wdata = 32'd130;
        exp_gnt.push_back(2'b10);
        #1;
        check("sw_mem_we", 32'(mem_we), 32'd1);
        check("sw_mem_addr", 32'(mem_addr), 32'd121);
        check("sw_mem_wdata", mem_wdata, 32'd130);
        next();
        d_we = 1'b0; d_addr = 10'd121; d_wdata = 32'd0;
        exp_gnt.push_back(2'b10); exp_d.push_back(32'd130);
        next();
        d_req = 1'b0;
        repeat (3) next();

        // Conflict: both requesting, pattern D,D,D,D,F repeating
        rst = 1'b1;
        next();
        rst = 1'b0;
        pat = 12'b0010_0001_0000;
        for (int i = 0; i < 12; i++) begin
`ifdef MEM_ARB_STATS_EN
            if (i == 10) begin
                check("stat_conflicts", 32'(stat_conflicts), 32'd10);
                check("stat_d_grants", 32'(stat_d_grants), 32'd8);
                check("stat_if_grants", 32'(stat_if_grants), 32'd2);
            end
`endif
            if_req = 1'b1; if_addr = 10'd5;
            d_req = 1'b1; d_we = 1'b0; d_addr = 10'd120;
            if (pat[i]) begin
                exp_gnt.push_back(2'b01); exp_if.push_back(32'h2801007D);
            end else begin
                exp_gnt.push_back(2'b10); exp_d.push_back(32'd85);
            end
            next();
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) next();

        // Halt after a load grant
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd120;
        exp_gnt.push_back(2'b10); exp_d.push_back(32'd85);
        next();
        d_req = 1'b0; halted = 1'b1; if_req = 1'b1; if_addr = 10'd2;
        exp_gnt.push_back(2'b00);
        check("halt_state_run", 32'(arb_state), 32'd0);
        next();
        check("halt_state_drain", 32'(arb_state), 32'd1);
        d_req = 1'b1;
        exp_gnt.push_back(2'b00);
        #1;
        check("drain_mem_en", 32'(mem_en), 32'd0);
        next();
        check("halt_state_halt", 32'(arb_state), 32'd2);
        halted = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_gnt.push_back(2'b00);
            #1;
            check("halt_sticky", 32'(arb_state), 32'd2);
            check("halt_mem_en", 32'(mem_en), 32'd0);
            next();
        end
        if_req = 1'b0; d_req = 1'b0;

        // Asynchronous reset one cycle after a fetch grant
        rst = 1'b1;
        next();
        rst = 1'b0;
        next();
        if_req = 1'b1; if_addr = 10'd3;
        exp_gnt.push_back(2'b01);
        next();
        if_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_state", 32'(arb_state), 32'd0);
        check("arst_if_rvalid", 32'(if_rvalid), 32'd0);
        check("arst_if_rdata", if_rdata, 32'd0);
        check("arst_d_rdata", d_rdata, 32'd0);
        check("arst_mem_en", 32'(mem_en), 32'd0);
        next();
        next();
        rst = 1'b0;
        repeat (3) next();

        check("if_queue_drained", 32'(exp_if.size()), 32'd0);
        check("d_queue_drained", 32'(exp_d.size()), 32'd0);
        check("gnt_queue_drained", 32'(exp_gnt.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips32_mem_arbiter.md
Name: mips32_mem_arbiter

Overview:
Single-clock arbiter sharing one single-port synchronous word memory between the mips32 instruction-fetch port (read-only) and the MEM-stage data port (LW/SW). Data port has fixed priority, since it belongs to the older instruction. A starvation guard forces a fetch grant after a bounded run of data grants. Honours the processor HALTED flag by draining in-flight reads and then freezing the memory port.

Parameters:
AW, 10, word-address width (1024 x 32-bit words)
DW, 32, data width
MAX_DSTREAK, 4, max consecutive data grants while if_req pending before fetch is forced (1..15)

Ports:
clk1  in  1  system clock, rising-edge
rst  in  1  asynchronous reset, active-high
halted  in  1  processor HALTED flag (HLT retired)
if_req  in  1  fetch request; held with if_addr stable until if_gnt
if_addr  in  AW  fetch word address
if_gnt  out  1  fetch granted this cycle (combinational)
if_rvalid  out  1  fetch read data valid (registered pulse)
if_rdata  out  DW  fetch read data
d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data word address
d_wdata  in  DW  store data
d_gnt  out  1  data granted this cycle (combinational)
d_rvalid  out  1  load data valid (registered pulse; never for stores)
d_rdata  out  DW  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid 1 cycle after mem_en & !mem_we
arb_state  out  2  FSM state, for debug

Behaviour:
- States: RUN=0, DRAIN=1, HALT=2. Reset: RUN; streak=0; if_rvalid=d_rvalid=0; if_rdata=d_rdata=0. Outputs if_gnt, d_gnt and mem_* are 0 under reset.
- RUN grant rule, evaluated combinationally each cycle:
  - d_req & !(if_req & streak==MAX_DSTREAK) -> d_gnt.
  - else if_req -> if_gnt.
  - At most one grant per cycle; mem_en = if_gnt|d_gnt.
- mem_* mux the granted port: mem_we = d_gnt & d_we; mem_wdata = d_wdata.
- Streak counter:
  - d_gnt while if_req=1 -> streak+1 (saturates at MAX_DSTREAK).
  - if_gnt, or no pending if_req -> streak=0.
- Read return: a granted read registers a 1-bit owner tag. Next cycle the owner's rvalid=1 and rdata=mem_rdata. rdata holds its value until the next valid for that port. Load latency: grant edge +1 cycle. Back-to-back grants sustain 1 access/cycle.
- Stores: committed at the grant edge; no rvalid; a read of the same address on the next grant returns the new value.
- halted rises in RUN: no grants from that cycle on; go to DRAIN. DRAIN -> HALT after any outstanding rvalid has issued (1 cycle max). HALT is sticky until rst; all grants and mem_en stay 0; rdata holds.
- Reset mid-access: outstanding rvalid is dropped, no pulse after reset; memory contents are not this block's concern.
- Requester dropping req before gnt is illegal; if it happens, the dropped request is simply not served (no stale grant).

Optional Feature:
MEM_ARB_STATS_EN: when defined, adds outputs stat_if_grants[15:0], stat_d_grants[15:0] and stat_conflicts[15:0]. stat_conflicts counts cycles with if_req & d_req both set. All three saturate at 16'hFFFF and clear on rst. When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Fetch only, if_addr=0..7 back-to-back, memory preloaded with eight words starting 32'h28010078 -> if_gnt every cycle; if_rvalid one cycle later each, data in order; no d_* activity.
- Load/store chain: LW at d_addr=120 (mem=85), then SW d_addr=121 with d_wdata=130 -> d_rvalid once with d_rdata=85; mem_we=1 at addr 121; a following LW of 121 returns 130.
- Conflict: if_req and d_req held high 12 cycles, MAX_DSTREAK=4 -> grant pattern D,D,D,D,F repeating; streak never exceeds 4; no cycle has both grants.
- halted asserted the cycle after a load grant -> d_rvalid still pulses once; arb_state 1 then 2; no mem_en afterwards despite requests; stays halted until rst.
- rst asserted asynchronously one cycle after a fetch grant -> if_rvalid never pulses; all outputs 0; arb_state=0.
- With MEM_ARB_STATS_EN, run the conflict scenario for 10 cycles -> stat_conflicts=10, stat_d_grants=8, stat_if_grants=2.
